// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants for the 4-bit ALU pre/post-processing blocks
//
// Purpose: op-code encoding, flag bit positions and result/flag widths shared by
//          the ALU operand preprocessor and the result postprocessor.
// Ports:   none (package).
package alu_pkg;

    localparam int RES_W = 4;              // result width
    localparam int FLG_W = 4;              // {Z, N, C, V}
    localparam int ENT_W = RES_W + FLG_W;  // one buffered entry

    // Arithmetic class op codes (Op[2] = 0)
    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_NEG  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_INC  = 3'b011;

    // Op[OP_LOGIC_BIT] = 1 selects the logic unit
    localparam int OP_LOGIC_BIT = 2;

    // Flag positions inside the 4-bit flags word
    localparam int FLG_Z = 3;
    localparam int FLG_N = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage

// File: rtl/res_fifo2.sv
// rtl/res_fifo2.sv - two-entry result FIFO with registered head output
//
// Purpose: holds up to two entries; dout always shows the head entry and keeps
//          the last popped value when empty (0 after reset).
// Ports:   clk, rst_n (sync active-low), push/din (write side),
//          pop/dout (read side), count (0..2 entries held).
module res_fifo2
    import alu_pkg::*;
#(
    parameter int DW = ENT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        do_push = push && (count_q != 2'd2);
        do_pop  = pop && (count_q != 2'd0);

        // Popping the last entry leaves head untouched so it keeps the last value.
        if (do_pop && (count_q == 2'd2)) begin
            head_d = tail_q;
        end

        if (do_push) begin
            // Push lands in head when head is empty or is leaving this cycle.
            if ((count_q == 2'd0) || do_pop) begin
                head_d = din;
            end else begin
                tail_d = din;
            end
        end

        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign dout  = head_q;
    assign count = count_q;

endmodule

// File: rtl/alu_postprocess.sv
// rtl/alu_postprocess.sv - ALU result select, flag generation and output buffering
//
// Purpose: selects adder or logic result by Op, computes {Z,N,C,V}, buffers
//          result+flags in a 2-entry FIFO, counts signed-overflow accepts.
// Ports:   clk, rst_n (sync active-low)
//          in_valid/in_ready, Op, AMod, BMod, S, Cout, L  (upstream side)
//          out_valid/out_ready, R, flags                   (consumer side)
//          ovf_cnt, ovf_clr                                (status)
module alu_postprocess
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Op,
    input  logic [3:0]       AMod,
    input  logic [3:0]       BMod,
    input  logic [3:0]       S,
    input  logic             Cout,
    input  logic [3:0]       L,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       R,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    logic             is_logic;
    logic [RES_W-1:0] res;
    logic [FLG_W-1:0] flg;
    logic             accept;
    logic             pop;
    logic [1:0]       count;
    logic [ENT_W-1:0] head;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             unused_op;

    // Only the class bit matters here; the low op bits shaped the operands upstream.
    assign unused_op = ^Op[1:0];

    assign is_logic = Op[OP_LOGIC_BIT];

    always_comb begin
        res = is_logic ? L : S;
        flg = '0;
        flg[FLG_Z] = (res == '0);
        flg[FLG_N] = res[RES_W-1];
        if (!is_logic) begin
            flg[FLG_C] = Cout;
            // Signed overflow: operands agree in sign, sum sign differs.
            flg[FLG_V] = (AMod[3] == BMod[3]) && (S[3] != AMod[3]);
        end
    end

    // Handshake derives from registered count only.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    res_fifo2 #(.DW(ENT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .din   ({res, flg}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign R     = head[ENT_W-1:FLG_W];
    assign flags = head[FLG_W-1:0];

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf_clr) begin
            ovf_cnt_d = '0;
        end else if (accept && flg[FLG_V] && (ovf_cnt_q != {CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_alu_postprocess.sv
// tb/tb_alu_postprocess.sv - scoreboard bench for alu_postprocess
module tb_alu_postprocess;

    localparam int CNT_W   = 8;
    localparam int OVF_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       Op;
    logic [3:0]       AMod, BMod, S, L;
    logic             Cout;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       R;
    logic [3:0]       flags;
    logic [CNT_W-1:0] ovf_cnt;
    logic             ovf_clr;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];
    int         exp_ovf = 0;
    bit         last_acc = 0;
    bit         ovf_known = 0;
    bit         rand_mode = 0;

    always #5 clk = ~clk;

    alu_postprocess #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Op        (Op),
        .AMod      (AMod),
        .BMod      (BMod),
        .S         (S),
        .Cout      (Cout),
        .L         (L),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .flags     (flags),
        .ovf_cnt   (ovf_cnt),
        .ovf_clr   (ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: expected {R, Z, N, C, V} from the operation's meaning.
    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] s,
                                         input logic c, input logic [3:0] l);
        logic [3:0] r;
        logic       cf, v;
        int         sa, sbv, sum;
        if (op[2]) begin
            r = l; cf = 1'b0; v = 1'b0;
        end else begin
            r   = s;
            cf  = c;
            sa  = int'($signed(a));
            sbv = int'($signed(b));
            sum = sa + sbv;
            v   = (sum > 7) || (sum < -8);
        end
        return {r, (r == 4'd0), r[3], cf, v};
    endfunction

    // One clock cycle: predict the coming edge at negedge, then step past it.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (ovf_known) check("ovf_cnt", 32'(ovf_cnt), 32'(exp_ovf));
        last_acc = 0;
        if (!rst_n) begin
            sb.delete();
            exp_ovf   = 0;
            ovf_known = 1;
        end else begin
            if (in_valid && in_ready) begin
                last_acc = 1;
                e = model(Op, AMod, BMod, S, Cout, L);
                sb.push_back(e);
                if (e[0] && exp_ovf < OVF_MAX) exp_ovf++;
            end
            if (ovf_clr) exp_ovf = 0;
        end
        @(posedge clk);
        #1;
        if (rand_mode) begin
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 31) == 0);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] s, input logic c, input logic [3:0] l);
        bit ok = 0;
        Op = op; AMod = a; BMod = b; S = s; Cout = c; L = l;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            tick();
            ok = last_acc;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept");
        end
    endtask

    task automatic send_arith(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] full;
        full = {1'b0, a} + {1'b0, b};
        send(op, a, b, full[3:0], full[4], 4'($urandom));
    endtask

    task automatic send_rand();
        logic [2:0] op;
        op = 3'($urandom);
        if (op[2]) send(op, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
        else       send_arith(op, 4'($urandom), 4'($urandom));
    endtask

    // Monitor: compares every popped head against the scoreboard.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1 && rst_n === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected no entry", {R, flags});
            end else begin
                check("head", {R, flags}, sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        Op = '0; AMod = '0; BMod = '0; S = '0; Cout = 1'b0; L = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_R", R, 0);
        check("rst_flags", flags, 0);
        check("rst_ovf", ovf_cnt, 0);

        // Signed overflow add, one-cycle latency
        out_ready = 1'b1;
        send_arith(3'b010, 4'b0111, 4'b0001);
        check("lat_valid", out_valid, 1);
        check("add_R", R, 4'b1000);
        check("add_flags", flags, 4'b0101);
        check("add_ovf", ovf_cnt, 1);

        // Negate to zero with carry
        send_arith(3'b001, 4'b0001, 4'b1111);
        check("neg_R", R, 4'b0000);
        check("neg_flags", flags, 4'b1010);
        check("neg_ovf", ovf_cnt, 1);

        // Logic op ignores the adder carry
        send(3'b101, 4'b0011, 4'b0101, 4'b1111, 1'b1, 4'b0000);
        check("log_R", R, 4'b0000);
        check("log_flags", flags, 4'b1000);
        tick();

        // Backpressure: two accepted, third held until drain
        out_ready = 1'b0;
        send(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0001);
        send(3'b100, 4'd0, 4'd0, 4'd0, 1'b0, 4'b0010);
        check("full_in_ready", in_ready, 0);
        Op = 3'b100; L = 4'b0011; in_valid = 1'b1;
        tick();
        check("held1", last_acc, 0);
        tick();
        check("held2", last_acc, 0);
        check("held_R", R, 4'b0001);
        out_ready = 1'b1;
        for (int i = 0; i < 8 && !last_acc; i++) tick();
        check("third_accept", last_acc, 1);
        in_valid = 1'b0;
        repeat (4) tick();
        check("drain_empty", sb.size(), 0);

        // Saturation of the overflow counter, then clear beats increment
        repeat (260) send_arith(3'b010, 4'b0111, 4'b0001);
        check("ovf_sat", ovf_cnt, OVF_MAX);
        ovf_clr = 1'b1;
        send_arith(3'b010, 4'b0111, 4'b0001);
        ovf_clr = 1'b0;
        check("ovf_clr", ovf_cnt, 0);
        repeat (3) tick();

        // Reset while full with a pending input
        out_ready = 1'b0;
        send_arith(3'b010, 4'b0111, 4'b0001);
        send_arith(3'b010, 4'b0111, 4'b0001);
        check("pre_rst_ovf", ovf_cnt, 2);
        Op = 3'b100; L = 4'b1001; in_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        check("mid_out_valid", out_valid, 0);
        check("mid_in_ready", in_ready, 1);
        check("mid_R", R, 0);
        check("mid_flags", flags, 0);
        check("mid_ovf", ovf_cnt, 0);
        tick();
        check("mid_not_accepted", out_valid, 0);

        // Randomized traffic with random backpressure and clears
        rand_mode = 1;
        repeat (400) begin
            send_rand();
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_mode = 0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        repeat (4) tick();
        check("final_empty", sb.size(), 0);
        check("final_out_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
